operand_fetch: RTL
==================

Name: operand_fetch

Overview:
- Stage directly upstream of the ALU (ports A, B, ALUOp).
- Holds the 32x32 general register file (GRF), reads two source registers and selects B as register or immediate.
- Latches {A, B, ALUOp, destination} into one output register, handed off with a valid/ready handshake.
- The write-back port feeds ALU results (C) back into the GRF, with internal write-to-read bypass.

Parameters:
- WIDTH, 32, datapath width of registers, A, B, immediate.
- NREG, 32, number of GRF entries; register 0 is hardwired to zero.
- AW, 5, register address width (log2 NREG).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream issue request.
- in_ready  out  1  stage can accept an issue this cycle.
- in_rs  in  AW  source register for A.
- in_rt  in  AW  source register for B when in_use_imm=0.
- in_imm  in  WIDTH  immediate for B when in_use_imm=1.
- in_use_imm  in  1  select immediate as B.
- in_aluop  in  3  operation code passed to the ALU (000 add, 001 sub, 100 srl, 101 sra; other codes passed through unchanged).
- in_rd  in  AW  destination register tag.
- wb_en  in  1  GRF write enable.
- wb_addr  in  AW  GRF write address.
- wb_data  in  WIDTH  GRF write data.
- out_valid  out  1  A/B/ALUOp/out_rd hold a valid operation.
- out_ready  in  1  ALU side consumes the operation.
- A  out  WIDTH  operand A.
- B  out  WIDTH  operand B.
- ALUOp  out  3  latched operation code.
- out_rd  out  AW  latched destination tag.

Behaviour:
- Reset:
  - Asserted asynchronously; takes effect immediately, with or without a clock edge.
  - Clears all GRF entries, out_valid, A, B, ALUOp and out_rd to 0.
  - Any in-flight operation is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready, purely combinational; no combinational path from in_valid to in_ready.
  - An issue happens when in_valid && in_ready at a rising edge. The output register loads that cycle, and out_valid=1 in the next cycle (latency 1).
  - Consume happens when out_valid && out_ready at an edge. If no new issue happens on the same edge, out_valid becomes 0.
  - Issue and consume on the same edge: the new operation replaces the old one and out_valid stays 1. This gives full throughput of 1 op/cycle.
  - While out_valid && !out_ready: A, B, ALUOp and out_rd are held stable and in_ready=0.
- Operand read:
  - GRF reads are combinational.
  - A = value of in_rs; B = in_use_imm ? in_imm : value of in_rt.
  - Reading address 0 always yields 0.
- Bypass: if wb_en && wb_addr==src && wb_addr!=0 in the same cycle as the issue, the operand takes wb_data instead of the stale GRF value.
- Write-back:
  - On an edge with wb_en && wb_addr!=0, GRF[wb_addr] <= wb_data.
  - Writes to address 0 are ignored.
  - Write-back proceeds regardless of the handshake state.
- Already latched operands are not updated by later write-backs; the ALU consumes the snapshot taken at issue.
- Widths: no arithmetic happens here. The immediate is used as given; sign/zero extension is the producer's responsibility.

Decomposition:
- Shared package holds:
  - WIDTH, AW, NREG.
  - ALU opcode constants: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_SRL=3'b100, ALU_SRA=3'b101.
- One sub-module, grf: 2 combinational read ports, 1 synchronous write port, async reset, $0 hardwired.
- The bypass mux, B select and output register with handshake live in operand_fetch.

Test Plan:
- Reset then issue (rs=0, rt=0, aluop=000, rd=3) -> next cycle out_valid=1, A=0, B=0, ALUOp=000, out_rd=3. Assert reset mid-cycle -> out_valid=0 immediately, no clock edge needed.
- Write-back then issue:
  - Stimulus: wb r1=1 and r2=2 on separate cycles, then issue rs=1, rt=2, aluop=001.
  - Required: A=1, B=2, ALUOp=001.
- Bypass: issue rs=5 in the same cycle as wb_en, wb_addr=5, wb_data=32'h8000_0000 -> A=32'h8000_0000. Same with wb_addr=0 -> A=0, and GRF[0] reads 0 afterwards.
- Immediate select: r4=32'h8000_0000, then issue rs=4, in_use_imm=1, imm=3, aluop=101 -> A=32'h8000_0000, B=3, ALUOp=101.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid=1 and changing inputs.
  - Required: in_ready=0, and A/B/ALUOp/out_rd unchanged for the whole stall.
  - Raise out_ready with in_valid=1 -> the next op loads on that edge and out_valid stays 1.
- Back-to-back throughput: 8 issues with out_ready=1 each cycle -> 8 consecutive valid outputs in order, no bubbles; out_valid drops the cycle after in_valid drops.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared sizing and ALU opcode constants for the operand fetch stage.
// Latency: n/a (constants only).
// Backpressure: n/a.
package operand_fetch_pkg;

  localparam int WIDTH = 32;
  localparam int NREG  = 32;
  localparam int AW    = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

endpackage

// File: rtl/operand_fetch_grf.sv
// General register file: 2 combinational read ports, 1 synchronous write port, $0 reads as zero.
// Latency: reads combinational, writes visible the cycle after the write edge.
// Backpressure: none; writes are accepted every cycle.
// Ports: clk/reset, ra_addr/ra_data, rb_addr/rb_data, we/wa/wd.
module operand_fetch_grf
  import operand_fetch_pkg::*;
#(
  parameter int W = WIDTH,
  parameter int N = NREG,
  parameter int A = AW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [A-1:0] ra_addr,
  output logic [W-1:0] ra_data,
  input  logic [A-1:0] rb_addr,
  output logic [W-1:0] rb_data,
  input  logic         we,
  input  logic [A-1:0] wa,
  input  logic [W-1:0] wd
);

  logic [W-1:0] regs [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Entry 0 is never written, but force zero on read so it is hardwired regardless.
  assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads rs/rt (or immediate) with write-back bypass and registers {A,B,ALUOp,rd}.
// Latency: 1 cycle from issue to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; output held stable while stalled.
// Ports: clk/reset, in_* issue handshake, wb_* register write-back, out_valid/out_ready + A/B/ALUOp/out_rd.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH_P = WIDTH,
  parameter int NREG_P  = NREG,
  parameter int AW_P    = AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AW_P-1:0]    in_rs,
  input  logic [AW_P-1:0]    in_rt,
  input  logic [WIDTH_P-1:0] in_imm,
  input  logic               in_use_imm,
  input  logic [2:0]         in_aluop,
  input  logic [AW_P-1:0]    in_rd,
  input  logic               wb_en,
  input  logic [AW_P-1:0]    wb_addr,
  input  logic [WIDTH_P-1:0] wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_P-1:0] A,
  output logic [WIDTH_P-1:0] B,
  output logic [2:0]         ALUOp,
  output logic [AW_P-1:0]    out_rd
);

  logic [WIDTH_P-1:0] rs_grf;
  logic [WIDTH_P-1:0] rt_grf;
  logic [WIDTH_P-1:0] rs_val;
  logic [WIDTH_P-1:0] rt_val;
  logic [WIDTH_P-1:0] b_val;
  logic               wb_live;
  logic               issue;

  operand_fetch_grf #(
    .W(WIDTH_P),
    .N(NREG_P),
    .A(AW_P)
  ) u_grf (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (in_rs),
    .ra_data (rs_grf),
    .rb_addr (in_rt),
    .rb_data (rt_grf),
    .we      (wb_en),
    .wa      (wb_addr),
    .wd      (wb_data)
  );

  // A write landing on the same edge as the issue is not yet in the GRF; forward it.
  assign wb_live = wb_en && (wb_addr != '0);
  assign rs_val  = (wb_live && (wb_addr == in_rs)) ? wb_data : rs_grf;
  assign rt_val  = (wb_live && (wb_addr == in_rt)) ? wb_data : rt_grf;
  assign b_val   = in_use_imm ? in_imm : rt_val;

  assign in_ready = !out_valid || out_ready;
  assign issue    = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      ALUOp     <= '0;
      out_rd    <= '0;
    end else if (issue) begin
      // Covers simultaneous consume: the new op replaces the old, valid stays high.
      out_valid <= 1'b1;
      A         <= rs_val;
      B         <= b_val;
      ALUOp     <= in_aluop;
      out_rd    <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
